// File: rtl/writeback_unit.sv
// Purpose: writeback stage; orders ALU/load results in a small FIFO and retires one regfile write per cycle.
// Latency: a result accepted at edge N can commit to the register file at edge N+1 at the earliest.
// Backpressure: ready comes only from the registered count; a load needs one free slot, an ALU result two if a load is also offered.
// Ports: clk/rst (sync, active-high); alu_*/ld_* producer valid/ready handshakes with rd and data;
//        writeAddr/writeData/writeEnable drive the regfile write port; fwd_addr*/fwd_hit*/fwd_data*
//        forward pending writes to decode; idle is high when no write is pending.
module writeback_unit #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             alu_valid,
   output logic             alu_ready,
   input  logic [4:0]       alu_rd,
   input  logic [31:0]      alu_data,
   input  logic             ld_valid,
   output logic             ld_ready,
   input  logic [4:0]       ld_rd,
   input  logic [31:0]      ld_data,
   output logic [4:0]       writeAddr,
   output logic [31:0]      writeData,
   output logic             writeEnable,
   input  logic [4:0]       fwd_addr1,
   input  logic [4:0]       fwd_addr2,
   output logic             fwd_hit1,
   output logic             fwd_hit2,
   output logic [31:0]      fwd_data1,
   output logic [31:0]      fwd_data2,
   output logic             idle
);

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_entry_t;

   wb_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] alu_slot;
   logic [PTR_W-1:0] fwd_idx;
   logic [PTR_W:0]   count;
   logic [PTR_W:0]   count_next;
   logic [PTR_W:0]   free;
   logic [PTR_W:0]   pushes;
   logic             ld_push;
   logic             alu_push;
   logic             pop;

   assign free      = (PTR_W+1)'(DEPTH) - count;
   assign ld_ready  = (free != '0);
   // The ALU may only take the last free slot when no load competes for it.
   assign alu_ready = (free >= (PTR_W+1)'(2)) || ((free != '0) && !ld_valid);

   // Writes to x0 complete the handshake but never occupy a slot.
   assign ld_push    = ld_valid && ld_ready && (ld_rd != 5'd0);
   assign alu_push   = alu_valid && alu_ready && (alu_rd != 5'd0);
   assign pop        = (count != '0);
   assign pushes     = (PTR_W+1)'(ld_push) + (PTR_W+1)'(alu_push);
   assign count_next = count + pushes - (PTR_W+1)'(pop);
   // The load is the older result, so it takes the first slot when both push.
   assign alu_slot   = wr_ptr + PTR_W'(ld_push);

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + PTR_W'(pushes);
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count_next;
      end
   end

   // Entry storage carries no reset; only the count decides which entries are live.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (ld_push) begin
            mem[wr_ptr] <= '{rd: ld_rd, data: ld_data};
         end
         if (alu_push) begin
            mem[alu_slot] <= '{rd: alu_rd, data: alu_data};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (int'(count) + int'(pushes) - int'(pop) <= DEPTH);
      end
   end

   // The write strobe is suppressed while rst is high so that a reset
   // arriving with writes pending lets none of them reach the register file.
   always_comb begin
      writeEnable = pop && !rst;
      writeAddr   = '0;
      writeData   = '0;
      if (writeEnable) begin
         writeAddr = mem[rd_ptr].rd;
         writeData = mem[rd_ptr].data;
      end
   end

   // Walk live entries oldest to youngest so the last match (youngest) wins.
   // The head that retires this cycle is still visible; this cycle's pushes are not.
   always_comb begin
      fwd_hit1  = 1'b0;
      fwd_hit2  = 1'b0;
      fwd_data1 = '0;
      fwd_data2 = '0;
      fwd_idx   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         fwd_idx = rd_ptr + PTR_W'(i);
         if ((PTR_W+1)'(i) < count) begin
            if ((fwd_addr1 != 5'd0) && (mem[fwd_idx].rd == fwd_addr1)) begin
               fwd_hit1  = 1'b1;
               fwd_data1 = mem[fwd_idx].data;
            end
            if ((fwd_addr2 != 5'd0) && (mem[fwd_idx].rd == fwd_addr2)) begin
               fwd_hit2  = 1'b1;
               fwd_data2 = mem[fwd_idx].data;
            end
         end
      end
   end

   assign idle = (count == '0);

endmodule

// File: tb/tb_writeback_unit.sv
// Testbench for writeback_unit: scoreboard of pending writes (queue) fed by the
// stimulus process; a negedge monitor retires entries against the DUT write port.
// Ports of the DUT are all connected; clock clk is generated here.
module tb_writeback_unit;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid, alu_ready, ld_valid, ld_ready;
   logic [4:0]  alu_rd, ld_rd, writeAddr, fwd_addr1, fwd_addr2;
   logic [31:0] alu_data, ld_data, writeData, fwd_data1, fwd_data2;
   logic        writeEnable, fwd_hit1, fwd_hit2, idle;

   int errors = 0;
   int checks = 0;

   // Pending register writes in program order: {rd, data}.
   logic [36:0] exp_q[$];
   logic [36:0] mon_e;

   writeback_unit #(.DEPTH(DEPTH), .PTR_W(2)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
      .writeAddr(writeAddr), .writeData(writeData), .writeEnable(writeEnable),
      .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2),
      .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
      .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
      .idle(idle)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Youngest pending write to a register wins; x0 is never forwarded.
   task automatic fwd_model(input logic [4:0] a, output logic hit, output logic [31:0] d);
      hit = 1'b0;
      d   = '0;
      if (a != 5'd0) begin
         for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i][36:32] == a) begin
               hit = 1'b1;
               d   = exp_q[i][31:0];
               break;
            end
         end
      end
   endtask

   // One clock of stimulus: drive inputs, check the DUT view of the current
   // pending set, then record which results the handshake accepts.
   task automatic step(input logic r,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldd,
                       input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic [4:0] f1, input logic [4:0] f2);
      int          cnt;
      int          free;
      logic        exp_lr, exp_ar, h;
      logic [31:0] d;
      @(posedge clk);
      #1;
      rst = r; ld_valid = lv; ld_rd = lrd; ld_data = ldd;
      alu_valid = av; alu_rd = ard; alu_data = ad;
      fwd_addr1 = f1; fwd_addr2 = f2;
      #1;
      if (r) begin
         exp_q.delete();
         return;
      end
      cnt    = exp_q.size();
      free   = DEPTH - cnt;
      exp_lr = (free >= 1);
      exp_ar = (free >= 2) || ((free >= 1) && !lv);
      chk("ld_ready", ld_ready, exp_lr);
      chk("alu_ready", alu_ready, exp_ar);
      chk("idle", idle, cnt == 0);
      chk("writeEnable", writeEnable, cnt > 0);
      if (cnt == 0) begin
         chk("writeAddr_empty", writeAddr, 0);
         chk("writeData_empty", writeData, 0);
      end
      fwd_model(f1, h, d);
      chk("fwd_hit1", fwd_hit1, h);
      chk("fwd_data1", fwd_data1, d);
      fwd_model(f2, h, d);
      chk("fwd_hit2", fwd_hit2, h);
      chk("fwd_data2", fwd_data2, d);
      if (lv && exp_lr && lrd != 5'd0) exp_q.push_back({lrd, ldd});
      if (av && exp_ar && ard != 5'd0) exp_q.push_back({ard, ad});
   endtask

   task automatic idle_step(input logic [4:0] f1, input logic [4:0] f2);
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, f1, f2);
   endtask

   // Monitor: every write strobe must retire the oldest pending entry.
   always @(negedge clk) begin
      if (writeEnable !== 1'b0) begin
         if (exp_q.size() == 0) begin
            chk("spurious_write", writeEnable, 1'b0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("writeAddr", writeAddr, mon_e[36:32]);
            chk("writeData", writeData, mon_e[31:0]);
         end
      end
   end

   initial begin
      rst = 1'b1; ld_valid = 1'b0; alu_valid = 1'b0;
      ld_rd = '0; alu_rd = '0; ld_data = '0; alu_data = '0;
      fwd_addr1 = '0; fwd_addr2 = '0;

      // Reset then idle.
      step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      idle_step(5'd0, 5'd0);

      // Single ALU write with forwarding, then idle.
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
      idle_step(5'd5, 5'd1);
      idle_step(5'd5, 5'd0);

      // Both producers, same rd: load older, ALU youngest for forwarding.
      step(1'b0, 1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22, 5'd0, 5'd7);
      idle_step(5'd7, 5'd7);
      idle_step(5'd7, 5'd7);
      idle_step(5'd0, 5'd0);

      // x0 results are accepted but dropped.
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234, 5'd0, 5'd0);
      idle_step(5'd0, 5'd0);
      idle_step(5'd0, 5'd0);

      // Backpressure: both producers held high with distinct rds.
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b1, 5'(1 + 2 * i), 32'h100 + i, 1'b1, 5'(2 + 2 * i), 32'h200 + i,
              5'(1 + 2 * i), 5'(2 * i));
      end
      for (int i = 0; i < DEPTH + 2; i++) idle_step(5'd3, 5'd4);

      // Reset mid-flight with three writes pending.
      step(1'b0, 1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB, 5'd0, 5'd0);
      step(1'b0, 1'b1, 5'd5, 32'hC, 1'b1, 5'd6, 32'hD, 5'd3, 5'd6);
      step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      idle_step(5'd5, 5'd6);
      idle_step(5'd3, 5'd4);

      // Randomized traffic with occasional resets and narrow rd range for collisions.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
         end else begin
            step(1'b0,
                 1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         end
      end

      for (int i = 0; i < DEPTH + 2; i++) idle_step(5'd0, 5'd0);
      @(negedge clk);
      #1;
      chk("drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Writeback stage that produces the write side of the 32x32 register file: write address, write data and write enable.
- Accepts results from two producers: single-cycle ALU and multi-cycle load unit.
- Buffers results in program order in a small FIFO and retires one write per cycle.
- Supplies forwarding data to decode for registers whose writes are still pending.

Parameters:
- DEPTH, 4, number of pending-write FIFO entries; power of two, at least 2.
- PTR_W, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- alu_valid  input  1  ALU result offered.
- alu_ready  output  1  ALU result accepted this cycle when alu_valid is also high.
- alu_rd  input  5  ALU destination register.
- alu_data  input  32  ALU result.
- ld_valid  input  1  load result offered.
- ld_ready  output  1  load result accepted this cycle when ld_valid is also high.
- ld_rd  input  5  load destination register.
- ld_data  input  32  load result.
- writeAddr  output  5  register file write address.
- writeData  output  32  register file write data.
- writeEnable  output  1  register file write strobe.
- fwd_addr1  input  5  decode read address, port 1.
- fwd_addr2  input  5  decode read address, port 2.
- fwd_hit1  output  1  pending write matches fwd_addr1.
- fwd_hit2  output  1  pending write matches fwd_addr2.
- fwd_data1  output  32  forwarded value for port 1.
- fwd_data2  output  32  forwarded value for port 2.
- idle  output  1  FIFO empty.

Behaviour:
- FIFO state: rd_ptr, wr_ptr, count (0..DEPTH), and per entry {rd[4:0], data[31:0]}.
- Reset (rst=1 at a rising edge): rd_ptr, wr_ptr and count cleared; entry valid state discarded.
- Outputs after reset:
  - writeEnable=0, writeAddr=0, writeData=0.
  - fwd_hit1=fwd_hit2=0, fwd_data1=fwd_data2=0.
  - idle=1.
  - ld_ready=1, and alu_ready=1.
- Reset mid-operation: all pending writes are dropped; none reach the register file.
- Ready logic is combinational from the registered count only; there is no credit for a same-cycle pop. free = DEPTH - count.
  - ld_ready = (free >= 1).
  - alu_ready = (free >= 2) or (free >= 1 and not ld_valid).
- Ordering: when both producers are accepted in the same cycle, the load result is older. It is enqueued first, then the ALU result; two pushes occur that cycle.
- x0 filter: an accepted result with rd=0 completes the handshake (ready honoured) but is not enqueued and does not consume a slot.
- Drain: when count>0, combinationally:
  - writeEnable=1.
  - writeAddr=head.rd.
  - writeData=head.data.
  - The head pops at the same clock edge at which the register file captures the write.
  - Exactly one retire per cycle.
- Empty FIFO: writeEnable=0, writeAddr=0, writeData=0.
- Latency: a result accepted at edge N is at the head no earlier than after edge N, so its write commits at edge N+1 at the earliest.
- Throughput: one retire per cycle. Two pushes and one pop in the same cycle give a net count of +1.
- count update: count_next = count + pushes - pop, where pushes is 0..2 and pop is 0..1. Pointers wrap modulo DEPTH.
- Overflow is impossible by construction; an assertion fires if count would exceed DEPTH.
- Forwarding (combinational), per port:
  - Search the valid entries from youngest to oldest for rd == fwd_addrN; the youngest match wins.
  - fwd_addr=0 never hits.
  - On a miss, hit=0 and data=0.
  - Entries being pushed this cycle are not visible; entries popping this cycle are visible.
- idle = (count == 0).

Test Plan:
- Reset then idle: rst high for 2 cycles, then all valids low → writeEnable=0, idle=1, alu_ready=ld_ready=1.
- Single ALU write: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for 1 cycle → next cycle writeEnable=1, writeAddr=5, writeData=0xDEADBEEF, fwd_addr1=5 gives fwd_hit1=1 with data 0xDEADBEEF; the cycle after that, idle=1.
- Simultaneous producers, same rd: ld (rd=7, 0x11) and alu (rd=7, 0x22) in the same cycle → writes retire in order 0x11 then 0x22; while both are pending, fwd_addr2=7 returns 0x22.
- x0 drop: alu_rd=0, alu_data=0x1234 accepted → alu_ready=1, idle stays 1, writeEnable never asserts.
- Backpressure: hold ld_valid and alu_valid high with distinct rd for 6 cycles with DEPTH=4 → count never exceeds 4; ld_ready stays 1 every cycle; alu_ready drops whenever free<2; all accepted results retire in order with no loss or duplication.
- Reset mid-flight: fill 3 entries, assert rst for 1 cycle → writeEnable=0 from the next cycle, idle=1, and none of the 3 pending writes is ever issued.
